cpu_alu_sequencer: RTL and testbench
====================================

# cpu_alu_sequencer

Multi-cycle controller that sequences the 8-bit combinational CPU ALU to execute 16-bit arithmetic and logic operations and 8x8 unsigned multiply. It sits between the CPU decode/execute stage (valid/ready request and response handshakes) and the ALU, drives the ALU operation, operands and flags every cycle, and owns the architectural flags register.

## Interface
- No parameters. Widths are fixed: 16-bit requests, 8-bit ALU, 4-bit flags.
- Flag bits: 0 = zero (Z), 1 = carry/borrow (C), 2 = sign (S), 3 = reserved.
- One clock; reset is asynchronous and active-low.

Ports:
- clock  in  1  sole clock, rising edge
- resetN  in  1  asynchronous active-low reset
- reqValid  in  1  request present
- reqReady  out  1  sequencer can accept a request
- reqOp  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 MUL, 7 reserved
- reqUseCarry  in  1  ADD/SUB only: fold the current flags C in as carry-in/borrow-in
- reqLeft  in  16  left operand; MUL uses [7:0]
- reqRight  in  16  right operand; MUL uses [7:0]; ignored for NOT
- respValid  out  1  result available
- respReady  in  1  consumer takes the result
- respResult  out  16  result
- respFlags  out  4  flags produced by this operation
- flagsOut  out  4  architectural flags register
- flagsWrite  in  1  load flagsWriteValue into flags (honoured in IDLE only)
- flagsWriteValue  in  4  value for flagsWrite
- aluOperation  out  5  ALU opcode: ADD 00000, ADDC 10000, SUB 00001, SUBC 10001, AND 00100, OR 00101, XOR 00110, NOT 00111
- aluFlagsIn  out  4  flags presented to the ALU
- aluLeft  out  8  ALU left operand
- aluRight  out  8  ALU right operand
- aluResult  in  8  ALU result
- aluFlags  in  4  ALU flags output

## Operation
States: IDLE, LO, HI, MUL, DONE.

IDLE
- reqReady = 1.
- ALU outputs are held at ADD, operands 0, aluFlagsIn = flagsOut.
- On reqValid, latch the request. Next state: LO for ops 0–5, MUL for op 6, DONE for op 7.

LO (low byte)
- ADD/SUB issue ADD/SUB. With reqUseCarry, issue ADDC/SUBC and drive aluFlagsIn = flagsOut.
- Logic ops issue their opcode.
- Capture the low result byte and aluFlags[C] into an internal carry.
- Next state: HI.

HI (high byte)
- ADD/SUB always issue ADDC/SUBC, with aluFlagsIn C = the captured internal carry.
- Capture the high result byte.
- Next state: DONE.

Flags for ops 0–5
- Z = (16-bit result == 0).
- S = result[15].
- C: ADD/SUB take the HI-step aluFlags[C] (carry out, or borrow for SUB); logic ops leave C unchanged.
- Bit 3 is always preserved.

MUL
- Shift-add over 8 iterations, counter 0..7.
- Internal registers: prodHi = 0, prodLo = multiplier, multiplicand = reqLeft[7:0], multiplier = reqRight[7:0].
- Each cycle: aluOperation = ADD, aluLeft = prodHi, aluRight = prodLo[0] ? multiplicand : 0.
- Register {aluFlags[C], aluResult, prodLo} >> 1 into {prodHi, prodLo}.
- After iteration 7: result = {prodHi, prodLo}; Z = (product == 0); C = (product[15:8] != 0); S = product[15].
- Next state: DONE.

Reserved op (7)
- result = 0, flags unchanged.

DONE
- respValid = 1. respResult and respFlags are held stable until respReady.
- When respReady: next state IDLE.
- The flags register is written on the same edge that enters DONE.

Reset
- Asynchronous, any state, including mid-operation: state = IDLE, flagsOut = 0, respValid = 0, respResult = 0, respFlags = 0, internal registers = 0.
- reqReady = 1 after reset.

## Timing
- Request handshake (reqValid && reqReady) completes at edge 0.
- Ops 0–5: LO in cycle 1, HI in cycle 2, respValid asserts in cycle 3.
- MUL: MUL state in cycles 1–8, respValid asserts in cycle 9.
- Reserved op: respValid asserts in cycle 1.
- The response handshake at edge N gives IDLE in cycle N+1. There is no same-cycle accept in DONE, so the maximum throughput is one op per 4 cycles.
- reqReady is combinational from state only (IDLE). It never depends on reqValid.
- The ALU is purely combinational. Its outputs are sampled on the edge that ends each LO/HI/MUL cycle.
- flagsWrite in any state other than IDLE is ignored. If flagsWrite and reqValid coincide in IDLE, the flags load takes effect first, so a reqUseCarry op in LO sees the new C.
- flagsOut changes only on the edge entering DONE, on an IDLE flagsWrite, or on reset.

## Test plan
- ADD 0x12FF + 0x0001, useCarry 0 -> aluOperation 00000 in cycle 1, 10000 in cycle 2; respResult 0x1300; Z=0 C=0 S=0; respValid first seen in cycle 3.
- SUB 0x0000 - 0x0001 -> respResult 0xFFFF; C=1, S=1, Z=0; flagsOut updated on the edge entering DONE.
- flagsWrite 0x2 (C=1), then ADD useCarry 0xFFFF + 0x0000 -> respResult 0x0000; Z=1, C=1.
- MUL 0xFF × 0xFF -> respResult 0xFE01; C=1, S=1, Z=0; respValid first seen in cycle 9. MUL 0x00 × 0x37 -> 0x0000 with Z=1.
- XOR 0xA5A5 ^ 0xA5A5 with prior C=1 -> result 0; Z=1, C stays 1. Hold respReady low 5 cycles -> respResult, respFlags and respValid stable, reqReady 0. Second reqValid is not accepted until the cycle after respReady.
- Drop resetN during MUL iteration 4 -> respValid 0, reqReady 1, flagsOut 0 immediately. After reset is released, ADD 0x0102 + 0x0304 -> 0x0406 in 3 cycles.

Source files
------------

// File: rtl/cpu_alu_sequencer_if.sv
// CPU-side bus of the ALU sequencer: request/response handshakes and flags-register access.
interface cpu_alu_sequencer_if;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqOp;
  logic        reqUseCarry;
  logic [15:0] reqLeft;
  logic [15:0] reqRight;
  logic        respValid;
  logic        respReady;
  logic [15:0] respResult;
  logic [3:0]  respFlags;
  logic [3:0]  flagsOut;
  logic        flagsWrite;
  logic [3:0]  flagsWriteValue;

  modport master (
    output reqValid, reqOp, reqUseCarry, reqLeft, reqRight, respReady,
           flagsWrite, flagsWriteValue,
    input  reqReady, respValid, respResult, respFlags, flagsOut
  );

  modport slave (
    input  reqValid, reqOp, reqUseCarry, reqLeft, reqRight, respReady,
           flagsWrite, flagsWriteValue,
    output reqReady, respValid, respResult, respFlags, flagsOut
  );
endinterface

// File: rtl/cpu_alu_sequencer.sv
// Sequences an 8-bit combinational ALU through 16-bit add/sub/logic ops and an
// 8x8 shift-add multiply; owns the architectural flags register.
module cpu_alu_sequencer (
  input  logic                      clock,
  input  logic                      resetN,
  cpu_alu_sequencer_if.slave        bus,
  output logic [4:0]                aluOperation,
  output logic [3:0]                aluFlagsIn,
  output logic [7:0]                aluLeft,
  output logic [7:0]                aluRight,
  input  logic [7:0]                aluResult,
  input  logic [3:0]                aluFlags
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LO = 3'd1, S_HI = 3'd2, S_MUL = 3'd3, S_DONE = 3'd4;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd6, OP_RSV = 3'd7;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_AND = 5'b00100, ALU_OR = 5'b00101,
                         ALU_XOR = 5'b00110, ALU_NOT = 5'b00111;
  localparam int FLAG_C = 1;

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        useCarry_q, useCarry_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic [15:0] result_q, result_d;  // doubles as {prodHi, prodLo} while multiplying
  logic        carry_q, carry_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  respFlags_q, respFlags_d;
  logic        isArith;
  logic        unusedAluFlags;

  function automatic logic [4:0] logic_opcode(input logic [2:0] op);
    case (op)
      3'd2:    logic_opcode = ALU_AND;
      3'd3:    logic_opcode = ALU_OR;
      3'd4:    logic_opcode = ALU_XOR;
      default: logic_opcode = ALU_NOT;
    endcase
  endfunction

  function automatic logic [3:0] make_flags(input logic rsv, input logic [15:0] res, input logic c);
    make_flags = {rsv, res[15], c, (res == 16'd0)};
  endfunction

  assign isArith        = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign unusedAluFlags = ^{aluFlags[3:2], aluFlags[0]};

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    useCarry_d   = useCarry_q;
    left_d       = left_q;
    right_d      = right_q;
    result_d     = result_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    flags_d      = flags_q;
    respFlags_d  = respFlags_q;
    aluOperation = ALU_ADD;
    aluFlagsIn   = flags_q;
    aluLeft      = 8'd0;
    aluRight     = 8'd0;
    case (state_q)
      S_IDLE: begin
        // A coincident flags load lands first so a carry-using op sees it in LO.
        if (bus.flagsWrite) flags_d = bus.flagsWriteValue;
        if (bus.reqValid) begin
          op_d       = bus.reqOp;
          useCarry_d = bus.reqUseCarry;
          left_d     = bus.reqLeft;
          right_d    = bus.reqRight;
          carry_d    = 1'b0;
          cnt_d      = 3'd0;
          case (bus.reqOp)
            OP_MUL: begin
              result_d = {8'd0, bus.reqRight[7:0]};
              state_d  = S_MUL;
            end
            OP_RSV: begin
              result_d    = 16'd0;
              respFlags_d = flags_d;
              state_d     = S_DONE;
            end
            default: state_d = S_LO;
          endcase
        end
      end
      S_LO: begin
        aluLeft       = left_q[7:0];
        aluRight      = right_q[7:0];
        aluOperation  = isArith ? {useCarry_q, 3'b000, op_q[0]} : logic_opcode(op_q);
        result_d[7:0] = aluResult;
        carry_d       = aluFlags[FLAG_C];
        state_d       = S_HI;
      end
      S_HI: begin
        aluLeft  = left_q[15:8];
        aluRight = right_q[15:8];
        if (isArith) begin
          aluOperation       = {1'b1, 3'b000, op_q[0]};
          aluFlagsIn[FLAG_C] = carry_q;
          flags_d = make_flags(flags_q[3], {aluResult, result_q[7:0]}, aluFlags[FLAG_C]);
        end else begin
          aluOperation = logic_opcode(op_q);
          flags_d = make_flags(flags_q[3], {aluResult, result_q[7:0]}, flags_q[FLAG_C]);
        end
        result_d[15:8] = aluResult;
        respFlags_d    = flags_d;
        state_d        = S_DONE;
      end
      S_MUL: begin
        aluLeft  = result_q[15:8];
        aluRight = result_q[0] ? left_q[7:0] : 8'd0;
        result_d = {aluFlags[FLAG_C], aluResult, result_q[7:1]};
        cnt_d    = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          flags_d     = make_flags(flags_q[3], result_d, (result_d[15:8] != 8'd0));
          respFlags_d = flags_d;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.respReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      useCarry_q  <= 1'b0;
      left_q      <= 16'd0;
      right_q     <= 16'd0;
      result_q    <= 16'd0;
      carry_q     <= 1'b0;
      cnt_q       <= 3'd0;
      flags_q     <= 4'd0;
      respFlags_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      useCarry_q  <= useCarry_d;
      left_q      <= left_d;
      right_q     <= right_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      flags_q     <= flags_d;
      respFlags_q <= respFlags_d;
    end
  end

  assign bus.reqReady   = (state_q == S_IDLE);
  assign bus.respValid  = (state_q == S_DONE);
  assign bus.respResult = result_q;
  assign bus.respFlags  = respFlags_q;
  assign bus.flagsOut   = flags_q;
endmodule

// File: tb/tb_cpu_alu_sequencer.sv
// Self-checking bench for cpu_alu_sequencer with a behavioural 8-bit ALU and a result scoreboard.
module tb_cpu_alu_sequencer;
  logic clock = 1'b0;
  logic resetN;
  always #5 clock = ~clock;

  cpu_alu_sequencer_if bus();
  logic [4:0] aluOperation;
  logic [3:0] aluFlagsIn;
  logic [7:0] aluLeft, aluRight;
  logic [7:0] aluResult;
  logic [3:0] aluFlags;

  cpu_alu_sequencer dut (
    .clock(clock), .resetN(resetN), .bus(bus),
    .aluOperation(aluOperation), .aluFlagsIn(aluFlagsIn),
    .aluLeft(aluLeft), .aluRight(aluRight),
    .aluResult(aluResult), .aluFlags(aluFlags)
  );

  // Behavioural ALU: 9th bit is carry-out for adds and borrow for subtracts.
  logic [8:0] aluSum;
  always_comb begin
    aluSum = 9'd0;
    case (aluOperation)
      5'b00000: aluSum = {1'b0, aluLeft} + {1'b0, aluRight};
      5'b10000: aluSum = {1'b0, aluLeft} + {1'b0, aluRight} + {8'd0, aluFlagsIn[1]};
      5'b00001: aluSum = {1'b0, aluLeft} - {1'b0, aluRight};
      5'b10001: aluSum = {1'b0, aluLeft} - {1'b0, aluRight} - {8'd0, aluFlagsIn[1]};
      5'b00100: aluSum = {aluFlagsIn[1], aluLeft & aluRight};
      5'b00101: aluSum = {aluFlagsIn[1], aluLeft | aluRight};
      5'b00110: aluSum = {aluFlagsIn[1], aluLeft ^ aluRight};
      5'b00111: aluSum = {aluFlagsIn[1], ~aluLeft};
      default:  aluSum = {aluFlagsIn[1], 8'd0};
    endcase
    aluResult = aluSum[7:0];
    aluFlags  = {aluFlagsIn[3], aluSum[7], aluSum[8], (aluSum[7:0] == 8'd0)};
  end

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mflags;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  function automatic exp_t model(input logic [2:0] op, input logic uc,
                                 input logic [15:0] l, input logic [15:0] r, input logic [3:0] f);
    logic [16:0] w;
    exp_t e;
    w = 17'd0;
    e.fl = f;
    case (op)
      3'd0: w = {1'b0, l} + {1'b0, r} + {16'd0, uc & f[1]};
      3'd1: w = {1'b0, l} - {1'b0, r} - {16'd0, uc & f[1]};
      3'd2: w = {f[1], l & r};
      3'd3: w = {f[1], l | r};
      3'd4: w = {f[1], l ^ r};
      3'd5: w = {f[1], ~l};
      3'd6: begin
        w[15:0] = {8'd0, l[7:0]} * {8'd0, r[7:0]};
        w[16]   = (w[15:8] != 8'd0);
      end
      default: w = 17'd0;
    endcase
    e.res = w[15:0];
    if (op != 3'd7) e.fl = {f[3], w[15], w[16], (w[15:0] == 16'd0)};
    return e;
  endfunction

  task automatic write_flags(input logic [3:0] v);
    bus.flagsWrite = 1'b1;
    bus.flagsWriteValue = v;
    @(posedge clock); #1;
    bus.flagsWrite = 1'b0;
    mflags = v;
  endtask

  // Returns one cycle after the handshake edge (cycle 1 of the operation).
  task automatic issue(input logic [2:0] op, input logic uc, input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    int n;
    n = 0;
    bus.reqValid = 1'b1;
    bus.reqOp = op;
    bus.reqUseCarry = uc;
    bus.reqLeft = l;
    bus.reqRight = r;
    while (bus.reqReady !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    e = model(op, uc, l, r, mflags);
    sb.push_back(e);
    mflags = e.fl;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
  endtask

  task automatic wait_resp(input int start, output int cyc);
    cyc = start;
    while (bus.respValid !== 1'b1 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic accept();
    bus.respReady = 1'b1;
    @(posedge clock); #1;
    bus.respReady = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    bus.reqValid = 1'b0; bus.reqOp = 3'd0; bus.reqUseCarry = 1'b0;
    bus.reqLeft = 16'd0; bus.reqRight = 16'd0; bus.respReady = 1'b0;
    bus.flagsWrite = 1'b0; bus.flagsWriteValue = 4'd0;
    mflags = 4'd0;
    repeat (2) @(posedge clock); #1;
    total_cnt++; if (bus.reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b want 1", bus.reqReady); else pass_cnt++;
    total_cnt++; if (bus.respValid !== 1'b0) $display("FAIL reset_respValid: got %b want 0", bus.respValid); else pass_cnt++;
    total_cnt++; if (bus.respResult !== 16'd0) $display("FAIL reset_respResult: got %h want 0000", bus.respResult); else pass_cnt++;
    total_cnt++; if (bus.flagsOut !== 4'd0 || bus.respFlags !== 4'd0) $display("FAIL reset_flags: got %h/%h want 0/0", bus.flagsOut, bus.respFlags); else pass_cnt++;
    total_cnt++; if (aluOperation !== 5'b00000 || aluLeft !== 8'd0 || aluRight !== 8'd0) $display("FAIL reset_alu: got %b %h %h want 00000 00 00", aluOperation, aluLeft, aluRight); else pass_cnt++;
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_add();
    exp_t e;
    int cyc;
    issue(3'd0, 1'b0, 16'h12FF, 16'h0001);
    total_cnt++; if (aluOperation !== 5'b00000 || aluLeft !== 8'hFF) $display("FAIL add_c1_alu: got %b %h want 00000 ff", aluOperation, aluLeft); else pass_cnt++;
    @(posedge clock); #1;
    total_cnt++; if (aluOperation !== 5'b10000 || aluFlagsIn[1] !== 1'b1) $display("FAIL add_c2_alu: got %b C=%b want 10000 C=1", aluOperation, aluFlagsIn[1]); else pass_cnt++;
    wait_resp(2, cyc);
    total_cnt++; if (cyc !== 3) $display("FAIL add_latency: got %0d want 3", cyc); else pass_cnt++;
    e = sb.pop_front();
    total_cnt++; if (bus.respResult !== e.res || bus.respResult !== 16'h1300) $display("FAIL add_result: got %h want %h", bus.respResult, e.res); else pass_cnt++;
    total_cnt++; if (bus.respFlags !== e.fl) $display("FAIL add_flags: got %b want %b", bus.respFlags, e.fl); else pass_cnt++;
    accept();
  endtask

  task automatic test_sub();
    exp_t e;
    int cyc;
    logic [3:0] prev;
    prev = mflags;
    issue(3'd1, 1'b0, 16'h0000, 16'h0001);
    @(posedge clock); #1;
    total_cnt++; if (bus.flagsOut !== prev) $display("FAIL sub_flags_early: got %b want %b", bus.flagsOut, prev); else pass_cnt++;
    wait_resp(2, cyc);
    e = sb.pop_front();
    total_cnt++; if (cyc !== 3) $display("FAIL sub_latency: got %0d want 3", cyc); else pass_cnt++;
    total_cnt++; if (bus.respResult !== e.res) $display("FAIL sub_result: got %h want %h", bus.respResult, e.res); else pass_cnt++;
    total_cnt++; if (bus.respFlags !== e.fl || bus.flagsOut !== e.fl) $display("FAIL sub_flags: got %b/%b want %b", bus.respFlags, bus.flagsOut, e.fl); else pass_cnt++;
    accept();
  endtask

  task automatic test_carry();
    exp_t e;
    int cyc;
    write_flags(4'h2);
    issue(3'd0, 1'b1, 16'hFFFF, 16'h0000);
    total_cnt++; if (aluOperation !== 5'b10000 || aluFlagsIn[1] !== 1'b1) $display("FAIL carry_c1_alu: got %b C=%b want 10000 C=1", aluOperation, aluFlagsIn[1]); else pass_cnt++;
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (bus.respResult !== e.res) $display("FAIL carry_result: got %h want %h", bus.respResult, e.res); else pass_cnt++;
    total_cnt++; if (bus.respFlags !== e.fl) $display("FAIL carry_flags: got %b want %b", bus.respFlags, e.fl); else pass_cnt++;
    accept();
  endtask

  task automatic test_mul();
    exp_t e;
    int cyc;
    issue(3'd6, 1'b0, 16'h00FF, 16'h00FF);
    total_cnt++; if (aluOperation !== 5'b00000 || aluRight !== 8'hFF) $display("FAIL mul_c1_alu: got %b %h want 00000 ff", aluOperation, aluRight); else pass_cnt++;
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (cyc !== 9) $display("FAIL mul_latency: got %0d want 9", cyc); else pass_cnt++;
    total_cnt++; if (bus.respResult !== e.res) $display("FAIL mul_result: got %h want %h", bus.respResult, e.res); else pass_cnt++;
    total_cnt++; if (bus.respFlags !== e.fl) $display("FAIL mul_flags: got %b want %b", bus.respFlags, e.fl); else pass_cnt++;
    accept();
    issue(3'd6, 1'b0, 16'h0000, 16'h0037);
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (bus.respResult !== e.res || bus.respFlags !== e.fl) $display("FAIL mul_zero: got %h/%b want %h/%b", bus.respResult, bus.respFlags, e.res, e.fl); else pass_cnt++;
    accept();
  endtask

  task automatic test_xor_hold();
    exp_t e, e2;
    int cyc;
    write_flags(4'h2);
    issue(3'd4, 1'b0, 16'hA5A5, 16'hA5A5);
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (bus.respResult !== e.res || bus.respFlags !== e.fl) $display("FAIL xor_result: got %h/%b want %h/%b", bus.respResult, bus.respFlags, e.res, e.fl); else pass_cnt++;
    bus.reqValid = 1'b1; bus.reqOp = 3'd0; bus.reqUseCarry = 1'b0;
    bus.reqLeft = 16'h0001; bus.reqRight = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      total_cnt++;
      if ({bus.respValid, bus.reqReady, bus.respResult, bus.respFlags} !== {1'b1, 1'b0, e.res, e.fl})
        $display("FAIL hold_stable_%0d: got v=%b r=%b %h %b want v=1 r=0 %h %b", i, bus.respValid, bus.reqReady, bus.respResult, bus.respFlags, e.res, e.fl);
      else pass_cnt++;
    end
    e2 = model(3'd0, 1'b0, 16'h0001, 16'h0001, mflags);
    sb.push_back(e2);
    mflags = e2.fl;
    bus.respReady = 1'b1;
    @(posedge clock); #1;
    bus.respReady = 1'b0;
    total_cnt++; if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0 || aluLeft !== 8'd0) $display("FAIL b2b_idle_gap: got r=%b v=%b left=%h want r=1 v=0 left=00", bus.reqReady, bus.respValid, aluLeft); else pass_cnt++;
    @(posedge clock); #1;
    bus.reqValid = 1'b0;
    total_cnt++; if (aluLeft !== 8'h01 || bus.reqReady !== 1'b0) $display("FAIL b2b_lo: got left=%h r=%b want left=01 r=0", aluLeft, bus.reqReady); else pass_cnt++;
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (cyc !== 3 || bus.respResult !== e.res) $display("FAIL b2b_result: got %h in cycle %0d want %h in cycle 3", bus.respResult, cyc, e.res); else pass_cnt++;
    accept();
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int cyc;
    write_flags(4'hB);
    issue(3'd6, 1'b0, 16'h0012, 16'h0034);
    repeat (4) @(posedge clock);
    #3;
    resetN = 1'b0;
    #1;
    total_cnt++; if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1) $display("FAIL rst_mul_hs: got v=%b r=%b want v=0 r=1", bus.respValid, bus.reqReady); else pass_cnt++;
    total_cnt++; if (bus.flagsOut !== 4'd0) $display("FAIL rst_mul_flags: got %b want 0000", bus.flagsOut); else pass_cnt++;
    sb.delete();
    mflags = 4'd0;
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
    issue(3'd0, 1'b0, 16'h0102, 16'h0304);
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (cyc !== 3 || bus.respResult !== e.res) $display("FAIL rst_add_result: got %h in cycle %0d want %h in cycle 3", bus.respResult, cyc, e.res); else pass_cnt++;
    accept();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc;
    logic [2:0] op;
    write_flags(4'hA);
    issue(3'd7, 1'b0, 16'hFFFF, 16'h1234);
    wait_resp(1, cyc);
    e = sb.pop_front();
    total_cnt++; if (cyc !== 1) $display("FAIL rsv_latency: got %0d want 1", cyc); else pass_cnt++;
    total_cnt++; if (bus.respResult !== e.res || bus.respFlags !== e.fl || bus.flagsOut !== 4'hA) $display("FAIL rsv_result: got %h/%b/%b want %h/%b/1010", bus.respResult, bus.respFlags, bus.flagsOut, e.res, e.fl); else pass_cnt++;
    accept();
    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 5));
      issue(op, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      wait_resp(1, cyc);
      e = sb.pop_front();
      total_cnt++;
      if (cyc !== 3 || bus.respResult !== e.res || bus.respFlags !== e.fl)
        $display("FAIL rand_op%0d_%0d: got %h/%b in cycle %0d want %h/%b in cycle 3", op, i, bus.respResult, bus.respFlags, cyc, e.res, e.fl);
      else pass_cnt++;
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_mul();
    test_xor_hold();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
